// File: rtl/pe_array_ctrl.sv
// Tile sequencer for the 64-PE bit-fusion array: accepts a tile command, streams
// operand-buffer reads, drives array controls and returns the drained partial sum.
module pe_array_ctrl #(
  parameter int ADDR_W    = 10,
  parameter int LEN_W     = 10,
  parameter int PSUM_W    = 32,
  parameter int BIAS_W    = 32,
  parameter int ARRAY_LAT = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_precision,
  input  logic [BIAS_W-1:0] cmd_bias,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              cmd_err,
  input  logic              stall,
  input  logic              abort,
  output logic              buf_rd_en,
  output logic [ADDR_W-1:0] buf_rd_addr,
  output logic [3:0]        arr_precision,
  output logic [BIAS_W-1:0] arr_bias,
  output logic              arr_sel_bias,
  output logic              arr_core_vld,
  output logic              arr_flush,
  input  logic [PSUM_W-1:0] arr_psum,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [PSUM_W-1:0] res_data,
  output logic              busy
);

  localparam int DW = $clog2(ARRAY_LAT + 1) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t            state_r;
  logic [3:0]        prec_r;
  logic [BIAS_W-1:0] bias_r;
  logic [ADDR_W-1:0] base_r;
  logic [LEN_W-1:0]  len_r;
  logic [LEN_W-1:0]  count_r;
  logic [DW-1:0]     drain_cnt_r;
  logic              cmd_ready_r;
  logic              cmd_err_r;
  logic              busy_r;
  logic              vld_r;
  logic              sel_r;
  logic              flush_r;
  logic              res_valid_r;
  logic [PSUM_W-1:0] res_data_r;

  logic              rd_en_s;
  logic              last_s;
  logic [ADDR_W-1:0] rd_addr_s;

  // Stall and abort must gate the read in the same cycle, so the strobe is decoded, not registered.
  assign rd_en_s   = (state_r == RUN) && !stall && !abort;
  assign last_s    = (count_r == (len_r - LEN_W'(1)));
  assign rd_addr_s = base_r + ADDR_W'(count_r);

  assign cmd_ready     = cmd_ready_r;
  assign cmd_err       = cmd_err_r;
  assign buf_rd_en     = rd_en_s;
  assign buf_rd_addr   = rd_en_s ? rd_addr_s : {ADDR_W{1'b0}};
  assign arr_precision = prec_r;
  assign arr_bias      = bias_r;
  assign arr_sel_bias  = sel_r;
  assign arr_core_vld  = vld_r;
  assign arr_flush     = flush_r;
  assign res_valid     = res_valid_r;
  assign res_data      = res_data_r;
  assign busy          = busy_r;

  // Tile sequencer state machine with registered control and status outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r     <= IDLE;
      prec_r      <= 4'd0;
      bias_r      <= {BIAS_W{1'b0}};
      base_r      <= {ADDR_W{1'b0}};
      len_r       <= {LEN_W{1'b0}};
      count_r     <= {LEN_W{1'b0}};
      drain_cnt_r <= {DW{1'b0}};
      cmd_ready_r <= 1'b0;
      cmd_err_r   <= 1'b0;
      busy_r      <= 1'b0;
      vld_r       <= 1'b0;
      sel_r       <= 1'b0;
      flush_r     <= 1'b0;
      res_valid_r <= 1'b0;
      res_data_r  <= {PSUM_W{1'b0}};
    end else begin
      cmd_err_r <= 1'b0;
      flush_r   <= 1'b0;
      // Delay by one so the beat lines up with the buffer's read data.
      vld_r     <= rd_en_s;
      sel_r     <= rd_en_s && (count_r == {LEN_W{1'b0}});
      case (state_r)
        IDLE: begin
          cmd_ready_r <= 1'b1;
          busy_r      <= 1'b0;
          if (cmd_valid && cmd_ready_r) begin
            if (cmd_len == {LEN_W{1'b0}}) begin
              cmd_err_r <= 1'b1;
            end else begin
              prec_r      <= cmd_precision;
              bias_r      <= cmd_bias;
              base_r      <= cmd_base;
              len_r       <= cmd_len;
              count_r     <= {LEN_W{1'b0}};
              state_r     <= RUN;
              cmd_ready_r <= 1'b0;
              busy_r      <= 1'b1;
            end
          end
        end
        RUN: begin
          if (abort) begin
            state_r     <= IDLE;
            flush_r     <= 1'b1;
            cmd_ready_r <= 1'b1;
            busy_r      <= 1'b0;
          end else if (rd_en_s) begin
            count_r <= count_r + LEN_W'(1);
            if (last_s) begin
              state_r     <= DRAIN;
              drain_cnt_r <= {DW{1'b0}};
            end
          end
        end
        DRAIN: begin
          if (abort) begin
            state_r     <= IDLE;
            flush_r     <= 1'b1;
            cmd_ready_r <= 1'b1;
            busy_r      <= 1'b0;
          end else if (drain_cnt_r == DW'(ARRAY_LAT)) begin
            res_data_r  <= arr_psum;
            res_valid_r <= 1'b1;
            state_r     <= HOLD;
          end else begin
            drain_cnt_r <= drain_cnt_r + DW'(1);
          end
        end
        HOLD: begin
          if (res_ready) begin
            res_valid_r <= 1'b0;
            state_r     <= IDLE;
            cmd_ready_r <= 1'b1;
            busy_r      <= 1'b0;
          end
        end
        default: begin
          state_r     <= IDLE;
          cmd_ready_r <= 1'b0;
          busy_r      <= 1'b0;
          res_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pe_array_ctrl.sv
// Directed bench for pe_array_ctrl: per-cycle output masks recorded over each tile
// and compared against hand-derived cycle patterns.
module tb_pe_array_ctrl;

  logic        CLK, RST;
  logic        cmd_valid, cmd_ready, cmd_err;
  logic [3:0]  cmd_precision, arr_precision;
  logic [31:0] cmd_bias, arr_bias;
  logic [9:0]  cmd_base, buf_rd_addr;
  logic [9:0]  cmd_len;
  logic        stall, abort, buf_rd_en, arr_sel_bias, arr_core_vld, arr_flush;
  logic [31:0] arr_psum, res_data;
  logic        res_valid, res_ready, busy;

  int n_chk  = 0;
  int n_pass = 0;

  logic [47:0] rd_m, vld_m, sel_m, fl_m, rv_m, rdy_m, busy_m, err_m;
  int          addr_q[$];
  logic [31:0] res_first;
  logic        res_seen, res_unstable;
  logic [3:0]  prec_at1;
  logic [31:0] bias_at1;

  pe_array_ctrl #(.ADDR_W(10), .LEN_W(10), .PSUM_W(32), .BIAS_W(32), .ARRAY_LAT(3)) dut (
    .CLK(CLK), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_precision(cmd_precision),
    .cmd_bias(cmd_bias), .cmd_base(cmd_base), .cmd_len(cmd_len), .cmd_err(cmd_err),
    .stall(stall), .abort(abort),
    .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr),
    .arr_precision(arr_precision), .arr_bias(arr_bias), .arr_sel_bias(arr_sel_bias),
    .arr_core_vld(arr_core_vld), .arr_flush(arr_flush), .arr_psum(arr_psum),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .busy(busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Cycle 0 presents the command; inputs change on falling edges, outputs sampled 1 unit later.
  task automatic run_tile(input logic [3:0] prec, input logic [31:0] bias, input logic [9:0] base,
                          input logic [9:0] len, input logic [47:0] stall_m, input logic [47:0] abort_m,
                          input logic [47:0] ready_m, input int ncyc);
    rd_m = '0; vld_m = '0; sel_m = '0; fl_m = '0; rv_m = '0; rdy_m = '0; busy_m = '0; err_m = '0;
    addr_q.delete();
    res_seen = 1'b0; res_unstable = 1'b0; res_first = 32'd0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge CLK);
      cmd_valid     = (i == 0);
      cmd_precision = prec;
      cmd_bias      = bias;
      cmd_base      = base;
      cmd_len       = len;
      stall         = stall_m[i];
      abort         = abort_m[i];
      res_ready     = ready_m[i];
      arr_psum      = 32'h100 + 32'(i);
      #1;
      rd_m[i] = buf_rd_en;  vld_m[i] = arr_core_vld; sel_m[i] = arr_sel_bias;
      fl_m[i] = arr_flush;  rv_m[i] = res_valid;     rdy_m[i] = cmd_ready;
      busy_m[i] = busy;     err_m[i] = cmd_err;
      if (buf_rd_en) addr_q.push_back(int'(buf_rd_addr));
      if (i == 1) begin prec_at1 = arr_precision; bias_at1 = arr_bias; end
      if (res_valid) begin
        if (!res_seen) begin res_first = res_data; res_seen = 1'b1; end
        else if (res_data !== res_first) res_unstable = 1'b1;
      end
    end
    cmd_valid = 1'b0; stall = 1'b0; abort = 1'b0; res_ready = 1'b0;
  endtask

  task automatic chk_addrs(input string tag, input int a0, input int a1, input int a2, input int a3, input int n);
    int exp_a[4];
    exp_a = '{a0, a1, a2, a3};
    chk_eq({tag, "_cnt"}, 64'(addr_q.size()), 64'(n));
    for (int k = 0; k < n && k < addr_q.size(); k++)
      chk_eq($sformatf("%s_%0d", tag, k), 64'(addr_q[k]), 64'(exp_a[k]));
  endtask

  function automatic logic any_out();
    return |{cmd_ready, cmd_err, buf_rd_en, buf_rd_addr, arr_precision, arr_bias, arr_sel_bias,
             arr_core_vld, arr_flush, res_valid, res_data, busy};
  endfunction

  initial begin
    cmd_valid = 1'b0; cmd_precision = 4'd0; cmd_bias = 32'd0; cmd_base = 10'd0; cmd_len = 10'd0;
    stall = 1'b0; abort = 1'b0; res_ready = 1'b0; arr_psum = 32'd0;
    RST = 1'b1;
    #1 RST = 1'b0;
    #12;
    chk_eq("reset_outs_zero", 64'(any_out()), 64'd0);
    @(negedge CLK); RST = 1'b1;
    @(negedge CLK); #1;
    chk_eq("reset_cmd_ready", 64'(cmd_ready), 64'd1);
    chk_eq("reset_busy", 64'(busy), 64'd0);

    // Single tile, no stall
    run_tile(4'b1010, 32'd100, 10'd5, 10'd4, 48'h0, 48'h0, {48{1'b1}}, 12);
    chk_addrs("t1_addr", 5, 6, 7, 8, 4);
    chk_eq("t1_rd", rd_m, 48'h1E);
    chk_eq("t1_vld", vld_m, 48'h3C);
    chk_eq("t1_sel", sel_m, 48'h4);
    chk_eq("t1_res_valid", rv_m, 48'h200);
    chk_eq("t1_res_data", 64'(res_first), 64'h108);
    chk_eq("t1_cmd_ready", rdy_m, 48'hC01);
    chk_eq("t1_busy", busy_m, 48'h3FE);
    chk_eq("t1_flush", fl_m, 48'h0);
    chk_eq("t1_prec", 64'(prec_at1), 64'hA);
    chk_eq("t1_bias", 64'(bias_at1), 64'd100);

    // Stalls at t+1 and t+3
    run_tile(4'b0101, 32'd7, 10'd20, 10'd3, 48'hA, 48'h0, {48{1'b1}}, 12);
    chk_addrs("t2_addr", 20, 21, 22, 0, 3);
    chk_eq("t2_rd", rd_m, 48'h34);
    chk_eq("t2_vld", vld_m, 48'h68);
    chk_eq("t2_sel", sel_m, 48'h8);
    chk_eq("t2_res_valid", rv_m, 48'h400);
    chk_eq("t2_res_data", 64'(res_first), 64'h109);

    // Illegal zero-length command
    run_tile(4'b1111, 32'd999, 10'd9, 10'd0, 48'h0, 48'h0, {48{1'b1}}, 4);
    chk_eq("t3_err", err_m, 48'h2);
    chk_eq("t3_busy", busy_m, 48'h0);
    chk_eq("t3_rd", rd_m, 48'h0);
    chk_eq("t3_cmd_ready", rdy_m, 48'hF);
    chk_eq("t3_prec_kept", 64'(arr_precision), 64'h5);
    chk_eq("t3_bias_kept", 64'(arr_bias), 64'd7);

    // Abort at beat 2 of 6, plus an abort while idle that must be ignored
    run_tile(4'b0000, 32'd1, 10'd100, 10'd6, 48'h0, 48'h48, {48{1'b1}}, 10);
    chk_eq("t4_rd", rd_m, 48'h6);
    chk_eq("t4_vld", vld_m, 48'hC);
    chk_eq("t4_sel", sel_m, 48'h4);
    chk_eq("t4_flush", fl_m, 48'h10);
    chk_eq("t4_res_valid", rv_m, 48'h0);
    chk_eq("t4_busy", busy_m, 48'hE);
    chk_eq("t4_cmd_ready", rdy_m, 48'h3F1);
    run_tile(4'b0110, 32'd3, 10'd0, 10'd2, 48'h0, 48'h0, {48{1'b1}}, 9);
    chk_eq("t4b_vld", vld_m, 48'hC);
    chk_eq("t4b_res_valid", rv_m, 48'h80);
    chk_eq("t4b_res_data", 64'(res_first), 64'h106);

    // Result backpressure: res_ready low for 5 cycles after res_valid rises
    run_tile(4'b1001, 32'd5, 10'd50, 10'd1, 48'h0, 48'h0, 48'hFFFF_FFFF_F800, 14);
    chk_eq("t5_res_valid", rv_m, 48'hFC0);
    chk_eq("t5_res_data", 64'(res_first), 64'h105);
    chk_eq("t5_res_stable", 64'(res_unstable), 64'd0);
    chk_eq("t5_cmd_ready", rdy_m, 48'h3001);

    // Address wrap
    run_tile(4'b0010, 32'd0, 10'd1022, 10'd4, 48'h0, 48'h0, {48{1'b1}}, 12);
    chk_addrs("t6_addr", 1022, 1023, 0, 1, 4);
    chk_eq("t6_rd", rd_m, 48'h1E);

    // Reset during DRAIN
    run_tile(4'b1010, 32'd11, 10'd300, 10'd4, 48'h0, 48'h0, {48{1'b1}}, 7);
    chk_eq("t7_busy_before", 64'(busy), 64'd1);
    #1 RST = 1'b0;
    #1;
    chk_eq("t7_outs_zero", 64'(any_out()), 64'd0);
    @(negedge CLK); RST = 1'b1;
    @(negedge CLK); #1;
    chk_eq("t7_cmd_ready", 64'(cmd_ready), 64'd1);
    rv_m = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK); res_ready = 1'b0; #1;
      rv_m[i] = res_valid;
    end
    chk_eq("t7_no_stale_res", rv_m, 48'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pe_array_ctrl.md
# pe_array_ctrl

Tile sequencer for the 64-PE bit-fusion dot-product array. It accepts one tile command: precision, bias, buffer base address and beat count. It then streams the activation/weight read addresses to the operand buffer and drives the array's precision, bias-select, valid and flush controls. After the array drains, it captures the accumulated partial sum and returns it through a valid/ready result port.

## Interface
- `ADDR_W`, 10: operand-buffer address width.
- `LEN_W`, 10: beat-count width.
- `PSUM_W`, 32: array partial-sum / result width.
- `BIAS_W`, 32: bias width.
- `ARRAY_LAT`, 3: cycles from an `arr_core_vld` beat to its contribution being visible on `arr_psum`.
- `CLK` in 1: clock, rising edge.
- `RST` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: tile command valid.
- `cmd_ready` out 1: controller idle and able to accept a command.
- `cmd_precision` in 4: {act[3:2], wgt[1:0]}, each field 00=1b, 01=2b, 10=4b.
- `cmd_bias` in BIAS_W: tile bias.
- `cmd_base` in ADDR_W: first operand-buffer address.
- `cmd_len` in LEN_W: number of beats; 0 is illegal.
- `cmd_err` out 1: one-cycle pulse when an illegal command is rejected.
- `stall` in 1: operand buffer not ready; no read is issued in this cycle.
- `abort` in 1: cancel the tile in flight.
- `buf_rd_en` out 1: operand-buffer read strobe; the buffer returns data one cycle later.
- `buf_rd_addr` out ADDR_W: read address.
- `arr_precision` out 4: precision to the array, held for the whole tile.
- `arr_bias` out BIAS_W: bias to the array.
- `arr_sel_bias` out 1: marks the first beat, which seeds the accumulator with the bias.
- `arr_core_vld` out 1: beat valid; the accumulator holds when low.
- `arr_flush` out 1: accumulator clear.
- `arr_psum` in PSUM_W: array partial sum.
- `res_valid` out 1: result valid.
- `res_ready` in 1: result accepted.
- `res_data` out PSUM_W: captured tile result.
- `busy` out 1: state is not IDLE.

## Operation
- States are IDLE, RUN, DRAIN and HOLD.
- **IDLE:** `cmd_ready`=1.
  - `cmd_valid` with `cmd_len`≠0: latch precision, bias, base and len; clear the beat counter; go to RUN.
  - `cmd_valid` with `cmd_len`=0: pulse `cmd_err`, stay in IDLE, leave the latched registers unchanged.
- **RUN:** each cycle with `stall`=0 asserts `buf_rd_en`, drives `buf_rd_addr`=base+count (wraps modulo 2^ADDR_W) and increments count.
  - A cycle with `stall`=1 issues nothing and leaves count unchanged.
  - When the read for beat len-1 issues, go to DRAIN.
- **Array controls:** `arr_core_vld` is `buf_rd_en` delayed one cycle, so it is aligned with the returned buffer data.
  - `arr_sel_bias` is (`buf_rd_en` && count==0) delayed one cycle. It is high only on the first beat, including when that beat follows stall cycles.
  - `arr_precision` and `arr_bias` come from the latched registers and are stable from the cycle after acceptance until the next acceptance.
- **DRAIN:** wait until ARRAY_LAT cycles after the last `arr_core_vld` beat. Then capture `arr_psum` into `res_data`, set `res_valid`, and go to HOLD.
- **HOLD:** keep `res_valid`=1 and `res_data` stable until `res_ready`=1. On that cycle clear `res_valid` and go to IDLE. A new command can be accepted from the following cycle.
- **Abort:** `abort` in RUN or DRAIN goes to IDLE on the next edge.
  - Pulse `arr_flush` for one cycle and suppress the pending `arr_core_vld` and `arr_sel_bias`.
  - Produce no result.
  - `abort` is ignored in IDLE and in HOLD.
- **Simultaneous events:** `abort` has priority over `stall` and over the transition to DRAIN.
- **Reset:** all outputs are 0 and the state is IDLE, so `cmd_ready` is 1 after reset release. Reset in mid-tile discards all state.

## Timing
- A command is accepted on edge t (`cmd_valid` && `cmd_ready`).
  - The first `buf_rd_en` is at cycle t+1, or later if `stall` is high.
  - The first `arr_core_vld` is one cycle after the first `buf_rd_en`.
- With no stalls, len beats give `arr_core_vld` at cycles t+2 … t+len+1.
  - `res_valid` rises at t+len+1+ARRAY_LAT+1.
- `cmd_err` and `arr_flush` are single-cycle registered pulses.
- `cmd_ready` is low from the cycle after acceptance until the cycle after the result handshake.
- Back-to-back tiles are not overlapped: a minimum one-cycle IDLE bubble separates them.

## Test plan
- **Single tile:** precision 4'b1010, bias 100, base 5, len 4, no stall.
  - `buf_rd_addr` 5,6,7,8 on consecutive cycles.
  - `arr_sel_bias` high only with the first `arr_core_vld`.
  - `res_valid` at t+4+ARRAY_LAT+2, with `res_data` equal to the array psum at that cycle.
- **Stalls:** len 3 with `stall` high at cycles t+1 and t+3.
  - Reads are issued only in non-stall cycles, the addresses contain no gaps, and 3 `arr_core_vld` pulses occur.
  - `arr_sel_bias` is on the first real beat only.
- **Illegal command:** `cmd_len`=0.
  - `cmd_err` pulses for one cycle, `busy` stays 0, and no `buf_rd_en` is issued.
- **Abort:** assert `abort` mid-RUN at beat 2 of 6.
  - `arr_flush` pulses once, no further `arr_core_vld`, `res_valid` never rises.
  - IDLE on the next cycle, and the next command completes normally.
- **Result backpressure and wrap:** hold `res_ready`=0 for 5 cycles; separately, run a tile with base=2^ADDR_W−2 and len 4.
  - `res_valid` and `res_data` stay stable and `cmd_ready`=0 until the handshake.
  - The wrap tile reads addresses 1022, 1023, 0, 1 (ADDR_W=10).
- **Reset mid-tile:** drop `RST` during DRAIN.
  - All outputs go to 0 immediately, `cmd_ready`=1 after release, and no stale `res_valid` appears.
